// File: rtl/test_node_traffic_monitor.sv
// Traffic monitor for AXI test nodes: beat/in-flight bookkeeping per
// channel plus a run/drain/done sequencer with drain timeout.
module test_node_traffic_monitor #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 32,
    parameter int MaxInFlight = 16,
    parameter int DrainCycles = 1024,
    localparam int IfWidth    = $clog2(MaxInFlight + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic [NumChannels-1:0]          ar_hs_i,
    input  logic [NumChannels-1:0]          aw_hs_i,
    input  logic [NumChannels-1:0]          r_hs_i,
    input  logic [NumChannels-1:0]          r_last_i,
    input  logic [NumChannels-1:0]          w_hs_i,
    input  logic [NumChannels-1:0]          b_hs_i,
    input  logic [NumChannels-1:0]          done_i,
    output logic [NumChannels*CntWidth-1:0] rd_beats_o,
    output logic [NumChannels*CntWidth-1:0] wr_beats_o,
    output logic [NumChannels*IfWidth-1:0]  rd_inflight_o,
    output logic [NumChannels*IfWidth-1:0]  wr_inflight_o,
    output logic [CntWidth-1:0]             cycles_o,
    output logic [NumChannels-1:0]          err_o,
    output logic [1:0]                      state_o,
    output logic                            end_of_sim_o,
    output logic                            timeout_o
);

    localparam int DcWidth = $clog2(DrainCycles + 1);
    localparam logic [DcWidth-1:0] DcLast = DcWidth'(DrainCycles - 1);
    localparam logic [IfWidth-1:0] IfMax = IfWidth'(MaxInFlight);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   to_timeout;
    logic   active;
    logic   all_idle;

    logic [DcWidth-1:0] drain_cnt_q;
    logic [CntWidth-1:0] cyc_q, cyc_d;
    logic eos_q, tmo_q;

    logic [NumChannels-1:0][CntWidth-1:0] rd_b_q, rd_b_d;
    logic [NumChannels-1:0][CntWidth-1:0] wr_b_q, wr_b_d;
    logic [NumChannels-1:0][IfWidth-1:0]  rd_if_q, rd_if_d;
    logic [NumChannels-1:0][IfWidth-1:0]  wr_if_q, wr_if_d;
    logic [NumChannels-1:0] err_q, err_d;
    logic [NumChannels-1:0] rd_bad, wr_bad;

    // Returns {protocol_error, next_count}; a balanced inc/dec is a no-op.
    function automatic logic [IfWidth:0] upd(
        input logic [IfWidth-1:0] cur,
        input logic               inc,
        input logic               dec
    );
        logic [IfWidth:0] res;
        res = {1'b0, cur};
        unique case (1'b1)
            (inc && !dec): begin
                if (cur == IfMax) res = {1'b1, cur};
                else res = {1'b0, cur + IfWidth'(1)};
            end
            (dec && !inc): begin
                if (cur == '0) res = {1'b1, cur};
                else res = {1'b0, cur - IfWidth'(1)};
            end
            default: res = {1'b0, cur};
        endcase
        return res;
    endfunction

    assign active   = (state_q == RUN) || (state_q == DRAIN);
    assign all_idle = (rd_if_q == '0) && (wr_if_q == '0);

    always_comb begin
        state_d    = state_q;
        to_timeout = 1'b0;
        unique case (state_q)
            IDLE:  if (en_i) state_d = RUN;
            RUN:   if (&done_i) state_d = DRAIN;
            DRAIN: begin
                // A clean drain takes priority over an expiring timer.
                if (all_idle) begin
                    state_d = DONE;
                end else if (drain_cnt_q == DcLast) begin
                    state_d    = DONE;
                    to_timeout = 1'b1;
                end
            end
            DONE:  state_d = DONE;
        endcase
    end

    always_comb begin
        rd_b_d  = rd_b_q;
        wr_b_d  = wr_b_q;
        rd_if_d = rd_if_q;
        wr_if_d = wr_if_q;
        err_d   = err_q;
        rd_bad  = '0;
        wr_bad  = '0;
        cyc_d   = cyc_q;
        if (active) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (r_hs_i[c] && rd_b_q[c] != '1)
                    rd_b_d[c] = rd_b_q[c] + CntWidth'(1);
                if (w_hs_i[c] && wr_b_q[c] != '1)
                    wr_b_d[c] = wr_b_q[c] + CntWidth'(1);
                {rd_bad[c], rd_if_d[c]} = upd(rd_if_q[c], ar_hs_i[c],
                                              r_hs_i[c] & r_last_i[c]);
                {wr_bad[c], wr_if_d[c]} = upd(wr_if_q[c], aw_hs_i[c],
                                              b_hs_i[c]);
                err_d[c] = err_q[c] | rd_bad[c] | wr_bad[c];
            end
            if (cyc_q != '1) cyc_d = cyc_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            cyc_q       <= '0;
            rd_b_q      <= '0;
            wr_b_q      <= '0;
            rd_if_q     <= '0;
            wr_if_q     <= '0;
            err_q       <= '0;
            eos_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            rd_b_q  <= rd_b_d;
            wr_b_q  <= wr_b_d;
            rd_if_q <= rd_if_d;
            wr_if_q <= wr_if_d;
            err_q   <= err_d;
            eos_q   <= (state_d == DONE);
            tmo_q   <= tmo_q | to_timeout;
            if (state_q == RUN) drain_cnt_q <= '0;
            else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + DcWidth'(1);
        end
    end

    assign rd_beats_o    = rd_b_q;
    assign wr_beats_o    = wr_b_q;
    assign rd_inflight_o = rd_if_q;
    assign wr_inflight_o = wr_if_q;
    assign cycles_o      = cyc_q;
    assign err_o         = err_q;
    assign state_o       = state_q;
    assign end_of_sim_o  = eos_q;
    assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_test_node_traffic_monitor.sv
// Bench for test_node_traffic_monitor: directed corner cases plus
// random traffic against a cycle-level behavioural model.
module tb_test_node_traffic_monitor;

    localparam int NC    = 2;
    localparam int CW    = 4;
    localparam int MAXIF = 16;
    localparam int DRN   = 8;
    localparam int IFW   = $clog2(MAXIF + 1);
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, en;
    logic [NC-1:0] ar_hs, aw_hs, r_hs, r_last, w_hs, b_hs, done;
    logic [NC*CW-1:0] rd_beats, wr_beats;
    logic [NC*IFW-1:0] rd_if, wr_if;
    logic [CW-1:0] cycles;
    logic [NC-1:0] err;
    logic [1:0] state;
    logic eos, tmo;

    int n_vec = 0;
    int n_err = 0;

    int m_state, m_cyc, m_dc;
    int m_rd_if[NC], m_wr_if[NC], m_rb[NC], m_wb[NC];
    bit m_err[NC];
    bit m_tmo;

    test_node_traffic_monitor #(
        .NumChannels(NC), .CntWidth(CW),
        .MaxInFlight(MAXIF), .DrainCycles(DRN)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .ar_hs_i(ar_hs), .aw_hs_i(aw_hs),
        .r_hs_i(r_hs), .r_last_i(r_last),
        .w_hs_i(w_hs), .b_hs_i(b_hs), .done_i(done),
        .rd_beats_o(rd_beats), .wr_beats_o(wr_beats),
        .rd_inflight_o(rd_if), .wr_inflight_o(wr_if),
        .cycles_o(cycles), .err_o(err), .state_o(state),
        .end_of_sim_o(eos), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_dc = 0; m_tmo = 0;
        for (int c = 0; c < NC; c++) begin
            m_rd_if[c] = 0; m_wr_if[c] = 0;
            m_rb[c] = 0; m_wb[c] = 0; m_err[c] = 0;
        end
    endtask

    task automatic model_edge();
        int outstanding, nr, nw;
        outstanding = 0;
        for (int c = 0; c < NC; c++)
            outstanding += m_rd_if[c] + m_wr_if[c];
        if (m_state == 1 || m_state == 2) begin
            for (int c = 0; c < NC; c++) begin
                m_rb[c] = sat(m_rb[c] + int'(r_hs[c]), CMAX);
                m_wb[c] = sat(m_wb[c] + int'(w_hs[c]), CMAX);
                nr = m_rd_if[c] + int'(ar_hs[c]) - int'(r_hs[c] & r_last[c]);
                nw = m_wr_if[c] + int'(aw_hs[c]) - int'(b_hs[c]);
                if (nr < 0 || nr > MAXIF || nw < 0 || nw > MAXIF)
                    m_err[c] = 1;
                m_rd_if[c] = sat(nr, MAXIF);
                m_wr_if[c] = sat(nw, MAXIF);
            end
            m_cyc = sat(m_cyc + 1, CMAX);
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (done == '1) begin m_state = 2; m_dc = 0; end
            2: begin
                m_dc++;
                if (outstanding == 0) m_state = 3;
                else if (m_dc == DRN) begin m_state = 3; m_tmo = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [NC*CW-1:0] erb, ewb;
        logic [NC*IFW-1:0] eri, ewi;
        logic [NC-1:0] ee;
        for (int c = 0; c < NC; c++) begin
            erb[c*CW +: CW] = CW'(m_rb[c]);
            ewb[c*CW +: CW] = CW'(m_wb[c]);
            eri[c*IFW +: IFW] = IFW'(m_rd_if[c]);
            ewi[c*IFW +: IFW] = IFW'(m_wr_if[c]);
            ee[c] = m_err[c];
        end
        chk("state", 64'(state), 64'(m_state));
        chk("rd_beats", 64'(rd_beats), 64'(erb));
        chk("wr_beats", 64'(wr_beats), 64'(ewb));
        chk("rd_inflight", 64'(rd_if), 64'(eri));
        chk("wr_inflight", 64'(wr_if), 64'(ewi));
        chk("cycles", 64'(cycles), 64'(m_cyc));
        chk("err", 64'(err), 64'(ee));
        chk("end_of_sim", 64'(eos), 64'(m_state == 3));
        chk("timeout", 64'(tmo), 64'(m_tmo));
    endtask

    task automatic clr();
        ar_hs = '0; aw_hs = '0; r_hs = '0; r_last = '0;
        w_hs = '0; b_hs = '0; done = '0; en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        clr();
        model_reset();
        do_reset();

        // handshakes before enable are ignored
        for (int i = 0; i < 5; i++) begin
            ar_hs = '1; aw_hs = '1; r_hs = '1; r_last = '1; w_hs = '1;
            step();
        end
        chk("pre_en_rd_beats", 64'(rd_beats), 64'(0));
        clr();

        // 3 reads on ch0, 9 beats with last on every third
        start_run();
        for (int i = 0; i < 3; i++) begin ar_hs = 2'b01; step(); end
        clr();
        for (int i = 0; i < 9; i++) begin
            r_hs = 2'b01; r_last = {1'b0, (i % 3) == 2}; step();
        end
        clr();
        done = 2'b11; step();
        done = 2'b00; step();
        chk("s032_rd_beats0", 64'(rd_beats[CW-1:0]), 64'(9));
        chk("s032_rd_if0", 64'(rd_if[IFW-1:0]), 64'(0));
        chk("s032_eos", 64'(eos), 64'(1));
        chk("s032_tmo", 64'(tmo), 64'(0));
        ar_hs = '1; w_hs = '1; step(); step();
        clr();

        // balanced inc/dec, then under- and overflow
        do_reset();
        start_run();
        ar_hs = 2'b01; step(); step();
        r_hs = 2'b01; r_last = 2'b01; step();
        chk("s033_rd_if0", 64'(rd_if[IFW-1:0]), 64'(2));
        chk("s033_err", 64'(err), 64'(0));
        clr();
        b_hs = 2'b10; step();
        chk("s034_wr_if1", 64'(wr_if[2*IFW-1:IFW]), 64'(0));
        chk("s034_err1", 64'(err[1]), 64'(1));
        clr(); step(); step();
        chk("s034_err1_sticky", 64'(err[1]), 64'(1));
        for (int i = 0; i < 17; i++) begin aw_hs = 2'b01; step(); end
        clr();
        chk("s034_wr_if0", 64'(wr_if[IFW-1:0]), 64'(16));
        chk("s034_err0", 64'(err[0]), 64'(1));

        // unanswered write -> drain timeout
        do_reset();
        start_run();
        aw_hs = 2'b01; step();
        clr();
        done = 2'b11; step();
        clr();
        n = 0;
        while (state != 2'd3 && n < 20) begin n++; step(); end
        chk("s035_drain_len", 64'(n), 64'(DRN));
        chk("s035_tmo", 64'(tmo), 64'(1));
        chk("s035_wr_if0", 64'(wr_if[IFW-1:0]), 64'(1));

        // in-flight clears exactly as the drain timer expires
        do_reset();
        start_run();
        aw_hs = 2'b01; step();
        clr();
        done = 2'b11; step();
        clr();
        for (int i = 0; i < DRN - 2; i++) step();
        b_hs = 2'b01; step();
        clr(); step();
        chk("s027_state", 64'(state), 64'(3));
        chk("s027_tmo", 64'(tmo), 64'(0));

        // asynchronous reset in the middle of DRAIN
        do_reset();
        start_run();
        ar_hs = '1; aw_hs = '1; r_hs = '1; w_hs = '1; step(); step();
        clr();
        done = 2'b11; step();
        clr(); step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("s036_state", 64'(state), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin ar_hs = '1; w_hs = '1; step(); end
        clr();

        // beat counter saturation
        do_reset();
        start_run();
        for (int i = 0; i < 20; i++) begin w_hs = 2'b01; step(); end
        clr();
        chk("s037_wr_beats0", 64'(wr_beats[CW-1:0]), 64'(15));

        // random traffic
        for (int run = 0; run < 6; run++) begin
            do_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                en = ($urandom_range(0, 7) == 0);
                ar_hs = 2'($urandom); aw_hs = 2'($urandom);
                r_hs = 2'($urandom); r_last = 2'($urandom);
                w_hs = 2'($urandom); b_hs = 2'($urandom);
                done = (cyc > 60 + run * 10) ? 2'($urandom | $urandom)
                                             : 2'($urandom & $urandom & $urandom);
                step();
            end
            clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
